// File: rtl/tick_enable_gen.sv
// Tick/enable generator: turns two push-button levels into a run/stop
// controlled periodic enable (period DIV clocks) plus single-step pulses
// while stopped, and counts every enable pulse it issues.
module tick_enable_gen #(
    parameter int unsigned DIV = 5,
    parameter int unsigned CW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_run,
    input  logic          btn_step,
    output logic          enable,
    output logic          running,
    output logic [CW-1:0] pulse_cnt
);

    localparam int unsigned   PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    if (DIV < 1 || DIV > 2**24) begin : g_bad_div
        $error("tick_enable_gen: DIV must be in 1..2^24");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Bit 0 = stage1, bit 1 = stage2, bit 2 = edge-detect flop.
    logic [2:0]    run_sync_q, run_sync_d;
    logic [2:0]    step_sync_q, step_sync_d;
    // Marks when stage2 holds a real sample rather than its reset value.
    logic [1:0]    smpl_vld_q, smpl_vld_d;
    // A button only arms once it has been seen low after reset, so a button
    // already held at release does not count as a press.
    logic          run_armed_q, run_armed_d;
    logic          step_armed_q, step_armed_d;
    logic          run_edge;
    logic          step_edge;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic          enable_q;
    logic          running_q;
    logic [CW-1:0] pulse_cnt_q, pulse_cnt_d;

    // Next-state for synchronizers, arming flags and the pulse counter.
    always_comb begin
        run_sync_d   = {run_sync_q[1:0], btn_run};
        step_sync_d  = {step_sync_q[1:0], btn_step};
        smpl_vld_d   = {smpl_vld_q[0], 1'b1};
        run_armed_d  = run_armed_q  | (smpl_vld_q[1] & ~run_sync_q[1]);
        step_armed_d = step_armed_q | (smpl_vld_q[1] & ~step_sync_q[1]);
        pulse_cnt_d  = pulse_cnt_q + CW'(enable_q);
    end

    assign run_edge  = run_sync_q[1]  & ~run_sync_q[2]  & run_armed_q;
    assign step_edge = step_sync_q[1] & ~step_sync_q[2] & step_armed_q;

    // Button synchronizers, arming flags and issued-pulse counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_sync_q   <= '0;
            step_sync_q  <= '0;
            smpl_vld_q   <= '0;
            run_armed_q  <= 1'b0;
            step_armed_q <= 1'b0;
            pulse_cnt_q  <= '0;
        end else begin
            run_sync_q   <= run_sync_d;
            step_sync_q  <= step_sync_d;
            smpl_vld_q   <= smpl_vld_d;
            run_armed_q  <= run_armed_d;
            step_armed_q <= step_armed_d;
            pulse_cnt_q  <= pulse_cnt_d;
        end
    end

    // Run/stop FSM with prescaler; enable and running are registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            enable_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_q <= '0;
                    if (run_edge) begin
                        state_q   <= RUN;
                        enable_q  <= 1'b0;
                        running_q <= 1'b1;
                    end else begin
                        enable_q  <= step_edge;
                        running_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (run_edge) begin
                        // Stopping wins over a wrap due on the same edge.
                        state_q   <= IDLE;
                        presc_q   <= '0;
                        enable_q  <= 1'b0;
                        running_q <= 1'b0;
                    end else if (presc_q == LAST) begin
                        presc_q  <= '0;
                        enable_q <= 1'b1;
                    end else begin
                        presc_q  <= presc_q + PW'(1);
                        enable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    presc_q   <= '0;
                    enable_q  <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign enable    = enable_q;
    assign running   = running_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_tick_enable_gen.sv
// Directed bench for tick_enable_gen: one instance with DIV=5/CW=16 and one
// with DIV=1/CW=4. Inputs change 1 time unit after a rising edge; outputs
// are sampled at the same point, so "after edge k" means just past edge k.
module tb_tick_enable_gen;

    logic        clk = 1'b0;
    logic        reset, btn_run, btn_step;
    logic        enable, running;
    logic [15:0] pulse_cnt;

    logic        reset1, btn_run1, btn_step1;
    logic        enable1, running1;
    logic [3:0]  pulse_cnt1;

    int n_chk = 0;
    int n_err = 0;

    tick_enable_gen #(.DIV(5), .CW(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn_run   (btn_run),
        .btn_step  (btn_step),
        .enable    (enable),
        .running   (running),
        .pulse_cnt (pulse_cnt)
    );

    tick_enable_gen #(.DIV(1), .CW(4)) u_dut1 (
        .clk       (clk),
        .reset     (reset1),
        .btn_run   (btn_run1),
        .btn_step  (btn_step1),
        .enable    (enable1),
        .running   (running1),
        .pulse_cnt (pulse_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
        reset1 = 1'b0; btn_run1 = 1'b0; btn_step1 = 1'b0;
        step(3);
        chk("rst_enable", enable, 0);
        chk("rst_running", running, 0);
        chk("rst_cnt", pulse_cnt, 0);
        reset = 1'b1;
        step(3);

        // Run press lands just before edge n; FSM acts at n+2.
        btn_run = 1'b1;
        step(2);
        chk("run_not_yet", running, 0);
        step(1);
        chk("run_on", running, 1);
        chk("en_at_entry", enable, 0);
        btn_run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("en_gap1", enable, 0);
        end
        step(1);
        chk("en_pulse1", enable, 1);
        step(1);
        chk("en_width1", enable, 0);
        chk("cnt_after1", pulse_cnt, 1);
        step(3);
        chk("en_gap2", enable, 0);
        step(1);
        chk("en_pulse2", enable, 1);
        step(1);
        chk("en_width2", enable, 0);
        chk("cnt_after2", pulse_cnt, 2);

        // Stop press timed so the FSM sees it on the edge a wrap is due.
        step(1);
        btn_run = 1'b1;
        step(2);
        chk("still_running", running, 1);
        step(1);
        chk("stopped", running, 0);
        chk("no_en_on_stop", enable, 0);
        btn_run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("idle_en", enable, 0);
        end
        chk("cnt_frozen", pulse_cnt, 2);

        // Three single-step presses, each held several cycles.
        for (int p = 0; p < 3; p++) begin
            btn_step = 1'b1;
            step(2);
            chk("step_not_yet", enable, 0);
            step(1);
            chk("step_pulse", enable, 1);
            step(1);
            chk("step_width", enable, 0);
            chk("step_cnt", pulse_cnt, 3 + p);
            chk("step_idle", running, 0);
            step(4);
            chk("step_held", enable, 0);
            btn_step = 1'b0;
            step(3);
        end

        // Run and step rise together: run wins, no step pulse.
        btn_run = 1'b1;
        btn_step = 1'b1;
        step(2);
        chk("sim_not_yet", running, 0);
        step(1);
        chk("sim_run", running, 1);
        chk("sim_no_step", enable, 0);
        btn_run = 1'b0;
        btn_step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("sim_gap", enable, 0);
        end
        step(1);
        chk("sim_pulse", enable, 1);
        chk("sim_cnt", pulse_cnt, 5);

        // Asynchronous reset while enable is high, between clock edges.
        #2;
        reset = 1'b0;
        #1;
        chk("arst_enable", enable, 0);
        chk("arst_running", running, 0);
        chk("arst_cnt", pulse_cnt, 0);
        btn_run = 1'b1;
        step(3);
        reset = 1'b1;
        step(8);
        chk("held_no_run", running, 0);
        chk("held_no_en", enable, 0);
        btn_run = 1'b0;
        step(3);
        btn_run = 1'b1;
        step(3);
        chk("rearm_run", running, 1);
        btn_run = 1'b0;

        // DIV=1, CW=4: enable every cycle, counter wraps.
        step(2);
        chk("d1_rst_en", enable1, 0);
        chk("d1_rst_cnt", pulse_cnt1, 0);
        reset1 = 1'b1;
        step(3);
        btn_run1 = 1'b1;
        step(2);
        chk("d1_not_yet", running1, 0);
        step(1);
        chk("d1_run", running1, 1);
        chk("d1_en_entry", enable1, 0);
        btn_run1 = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            step(1);
            chk("d1_en", enable1, 1);
            chk("d1_cnt", pulse_cnt1, (i - 1) % 16);
        end
        step(1);
        chk("d1_cnt_wrap", pulse_cnt1, 1);
        chk("d1_en_cont", enable1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tick_enable_gen.md
TICK_ENABLE_GEN -- requirements
Module: tick_enable_gen

Interface
REQ-001 Parameter: DIV, default 5, enable-pulse period in clk cycles while running; legal range 1..2^24; DIV=0 SHALL fail elaboration.
REQ-002 Parameter: CW, default 16, width of the issued-pulse counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 btn_run  input  1  asynchronous level from push button; each rising edge toggles run/stop.
REQ-006 btn_step  input  1  asynchronous level from push button; each rising edge requests one enable pulse while stopped.
REQ-007 enable  output  1  registered one-cycle pulse feeding the downstream counter's enable input.
REQ-008 running  output  1  registered, high while in RUN state.
REQ-009 pulse_cnt  output  CW  registered count of enable pulses issued.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer followed by a third flop; edge pulse = stage2 & ~stage3.
REQ-011 Button rising between edges n-1 and n SHALL produce its edge pulse during the cycle after edge n+1; the FSM acts on it at edge n+2.
REQ-012 A button held high SHALL produce exactly one edge pulse; no further action until it falls and rises again.
REQ-013 FSM states: IDLE, RUN; encoding free.
REQ-014 IDLE + run edge -> RUN at that clock edge; prescaler cleared to 0; running=1 from that edge.
REQ-015 RUN + run edge -> IDLE at that clock edge; prescaler cleared to 0; enable=0 at that edge, even if a wrap was due.
REQ-016 In RUN, each edge: if prescaler == DIV-1 then prescaler <= 0 and enable <= 1, else prescaler <= prescaler+1 and enable <= 0.
REQ-017 First enable pulse after entering RUN at edge m SHALL be high during the cycle after edge m+DIV; subsequent pulses every DIV cycles, width exactly one cycle.
REQ-018 DIV=1: enable SHALL be high every cycle while in RUN, starting the cycle after edge m+1.
REQ-019 IDLE + step edge (no run edge) -> enable <= 1 for exactly one cycle at that edge; state stays IDLE.
REQ-020 Step edge in RUN SHALL be ignored, with no effect on prescaler or enable.
REQ-021 Simultaneous run and step edges in IDLE: run edge wins (REQ-014), step ignored.
REQ-022 Prescaler width SHALL be $clog2(DIV) bits, minimum 1; prescaler SHALL never exceed DIV-1.
REQ-023 pulse_cnt SHALL increment by 1 at the edge following each cycle where enable=1; modulo 2^CW wrap (all-ones -> 0), no saturation.
REQ-024 pulse_cnt SHALL hold its value across RUN/IDLE transitions; cleared only by reset.
REQ-025 In IDLE with no step edge, enable=0 and prescaler holds 0.

Reset
REQ-026 reset=0 SHALL immediately, independent of clk, force: all synchronizer flops 0, state IDLE, prescaler 0, enable 0, running 0, pulse_cnt 0.
REQ-027 Reset asserted mid-RUN or mid-pulse SHALL drop enable and running within the same cycle, with no partial pulse after release.
REQ-028 After reset release, normal operation SHALL start at the first rising clk edge; a button already held high at release SHALL NOT generate an edge pulse.

Verification
REQ-029 DIV=5: reset, release, btn_run rise before edge 10 -> running=1 after edge 12; enable pulses during the cycles after edges 17, 22, 27; each 1 cycle wide.
REQ-030 DIV=5, running, second btn_run press acting at edge 20 -> running=0 after edge 20; no enable after edge 20; pulse_cnt frozen at 1.
REQ-031 IDLE, three separate btn_step presses -> exactly three one-cycle enable pulses, each 2 edges after the sync stage1 capture; pulse_cnt=3; running stays 0.
REQ-032 IDLE, btn_run and btn_step rising in the same cycle -> RUN entered, no step pulse; next enable DIV cycles later.
REQ-033 DIV=1, CW=4, run for 17 cycles -> enable continuously high; pulse_cnt wraps 15 -> 0 and reads 1 after the 17th pulse.
REQ-034 reset=0 asynchronously mid-RUN while enable=1 -> enable, running, pulse_cnt read 0 before the next clk edge; btn_run held high through release -> state stays IDLE.
